// File: rtl/ram_1r1w_sync.sv
// Single-clock RAM, one synchronous read port and one write port.
// Read data is registered and held between reads so callers can consume it
// later (the data-memory read-modify-write path depends on that).
// Storage is intentionally never reset so a hierarchical preload of mem
// survives the reset sequence.
module ram_1r1w_sync #(
  parameter int width_p = 32,
  parameter int depth_p = 1024,
  localparam int addr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_valid_i,
  input  logic [width_p-1:0]   wr_data_i,
  input  logic [addr_w_lp-1:0] wr_addr_i,
  input  logic                 rd_valid_i,
  input  logic [addr_w_lp-1:0] rd_addr_i,
  output logic [width_p-1:0]   rd_data_o
);

  // One extra bit so depth_p itself is representable for the range compare.
  localparam logic [addr_w_lp:0] depth_lp = depth_p[addr_w_lp:0];

  logic [width_p-1:0] mem [0:depth_p-1];

  logic wr_in_range;
  logic rd_in_range;

  // Address range qualification; only matters for non power-of-two depths.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr_i} < depth_lp);
    rd_in_range = ({1'b0, rd_addr_i} < depth_lp);
  end

  // Write port: no reset on the array, writes ignored while reset is held.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_valid_i && wr_in_range) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: read-first on collision because mem is sampled before the
  // same-edge write lands; output holds when rd_valid_i is low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o <= '0;
    end else if (rd_valid_i) begin
      rd_data_o <= rd_in_range ? mem[rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_ram_1r1w_sync.sv
// Directed bench for ram_1r1w_sync at default parameters (32 x 1024).
module tb_ram_1r1w_sync;

  logic        clk_i;
  logic        reset_i;
  logic        wr_valid_i;
  logic [31:0] wr_data_i;
  logic [9:0]  wr_addr_i;
  logic        rd_valid_i;
  logic [9:0]  rd_addr_i;
  logic [31:0] rd_data_o;

  int errors;
  int checks;

  ram_1r1w_sync #(.width_p(32), .depth_p(1024)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_addr_i  (wr_addr_i),
    .rd_valid_i (rd_valid_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; inputs changed after this are
  // sampled at the following edge, outputs observed here reflect this edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    wr_valid_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    rd_valid_i = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [9:0] a);
    rd_valid_i = 1'b1; rd_addr_i = a;
    wr_valid_i = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset_i = 1'b1; idle(); wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
    // Hierarchical preload of mem before reset release.
    dut.mem[0] = 32'h0000_0013;
    tick(); tick();
    checks++;
    if (rd_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_state: got %h want %h", rd_data_o, 32'h0);
    end
    #3 reset_i = 1'b0;
    tick();
  endtask

  task automatic test_preload();
    do_read(10'd0);
    checks++;
    if (rd_data_o !== 32'h0000_0013) begin
      errors++; $display("FAIL preload: got %h want %h", rd_data_o, 32'h0000_0013);
    end
  endtask

  task automatic test_write_read();
    do_write(10'd5, 32'hDEAD_BEEF);
    do_write(10'd6, 32'h1234_5678);
    do_read(10'd5);
    checks++;
    if (rd_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read5: got %h want %h", rd_data_o, 32'hDEAD_BEEF);
    end
    do_read(10'd6);
    checks++;
    if (rd_data_o !== 32'h1234_5678) begin
      errors++; $display("FAIL read6: got %h want %h", rd_data_o, 32'h1234_5678);
    end
  endtask

  task automatic test_hold();
    logic [9:0]  wa [3];
    logic [31:0] wd [3];
    wa[0] = 10'd5; wd[0] = 32'h0;
    wa[1] = 10'd7; wd[1] = 32'hAAAA_5555;
    wa[2] = 10'd8; wd[2] = 32'h0808_0808;
    do_read(10'd5);
    checks++;
    if (rd_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL hold_read: got %h want %h", rd_data_o, 32'hDEAD_BEEF);
    end
    for (int i = 0; i < 3; i++) begin
      do_write(wa[i], wd[i]);
      checks++;
      if (rd_data_o !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL hold_cycle%0d: got %h want %h", i, rd_data_o, 32'hDEAD_BEEF);
      end
    end
  endtask

  task automatic test_collision();
    do_write(10'd9, 32'h1111_1111);
    wr_valid_i = 1'b1; wr_addr_i = 10'd9; wr_data_i = 32'h2222_2222;
    rd_valid_i = 1'b1; rd_addr_i = 10'd9;
    tick(); idle();
    checks++;
    if (rd_data_o !== 32'h1111_1111) begin
      errors++; $display("FAIL collision_old: got %h want %h", rd_data_o, 32'h1111_1111);
    end
    do_read(10'd9);
    checks++;
    if (rd_data_o !== 32'h2222_2222) begin
      errors++; $display("FAIL collision_new: got %h want %h", rd_data_o, 32'h2222_2222);
    end
    // Different addresses at the same edge are independent.
    wr_valid_i = 1'b1; wr_addr_i = 10'd10; wr_data_i = 32'h0A0A_0A0A;
    rd_valid_i = 1'b1; rd_addr_i = 10'd7;
    tick(); idle();
    checks++;
    if (rd_data_o !== 32'hAAAA_5555) begin
      errors++; $display("FAIL diff_addr_read: got %h want %h", rd_data_o, 32'hAAAA_5555);
    end
    do_read(10'd10);
    checks++;
    if (rd_data_o !== 32'h0A0A_0A0A) begin
      errors++; $display("FAIL diff_addr_write: got %h want %h", rd_data_o, 32'h0A0A_0A0A);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  ra [5];
    logic [31:0] re [5];
    ra[0] = 10'd7;  re[0] = 32'hAAAA_5555;
    ra[1] = 10'd6;  re[1] = 32'h1234_5678;
    ra[2] = 10'd5;  re[2] = 32'h0;
    ra[3] = 10'd8;  re[3] = 32'h0808_0808;
    ra[4] = 10'd0;  re[4] = 32'h0000_0013;
    rd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_addr_i = ra[i];
      tick();
      checks++;
      if (rd_data_o !== re[i]) begin
        errors++; $display("FAIL b2b_%0d: got %h want %h", i, rd_data_o, re[i]);
      end
    end
    idle();
  endtask

  task automatic test_boundaries();
    logic [9:0]  ba [4];
    logic [31:0] be [4];
    do_write(10'd1,    32'h0101_0101);
    do_write(10'd1022, 32'h1022_1022);
    do_write(10'd0,    32'hCAFE_F00D);
    do_write(10'd1023, 32'h0BAD_C0DE);
    ba[0] = 10'd0;    be[0] = 32'hCAFE_F00D;
    ba[1] = 10'd1023; be[1] = 32'h0BAD_C0DE;
    ba[2] = 10'd1;    be[2] = 32'h0101_0101;
    ba[3] = 10'd1022; be[3] = 32'h1022_1022;
    for (int i = 0; i < 4; i++) begin
      do_read(ba[i]);
      checks++;
      if (rd_data_o !== be[i]) begin
        errors++; $display("FAIL boundary_%0d: addr %0d got %h want %h", i, ba[i], rd_data_o, be[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_write(10'd3, 32'h55AA_55AA);
    do_read(10'd3);
    checks++;
    if (rd_data_o !== 32'h55AA_55AA) begin
      errors++; $display("FAIL rst_preread: got %h want %h", rd_data_o, 32'h55AA_55AA);
    end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (rd_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_async: got %h want %h", rd_data_o, 32'h0);
    end
    // Traffic during reset must be ignored.
    wr_valid_i = 1'b1; wr_addr_i = 10'd3; wr_data_i = 32'hFFFF_0000;
    rd_valid_i = 1'b1; rd_addr_i = 10'd3;
    tick();
    checks++;
    if (rd_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_held: got %h want %h", rd_data_o, 32'h0);
    end
    idle();
    #3 reset_i = 1'b0;
    tick();
    checks++;
    if (rd_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_release_idle: got %h want %h", rd_data_o, 32'h0);
    end
    do_read(10'd3);
    checks++;
    if (rd_data_o !== 32'h55AA_55AA) begin
      errors++; $display("FAIL rst_retained: got %h want %h", rd_data_o, 32'h55AA_55AA);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_preload();
    test_write_read();
    test_hold();
    test_collision();
    test_back_to_back();
    test_boundaries();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
